arb_mux_reg: RTL and testbench
==============================

// Module: arb_mux_reg
// PURPOSE
//  Parametrised, registered N-channel W-bit selector for operand/writeback paths in the multicycle datapath.
//  Each source channel uses a valid/ready handshake. The output is a one-entry register with valid/ready.
//  Two runtime modes select the source:
//   - fixed select (mode=0): the sel input chooses the channel.
//   - round-robin arbitration (mode=1): the block grants among the channels that are valid.
//  Adds backpressure, source tagging and select-range checking.
// PARAMETERS
//  WIDTH  16  data width per channel
//  NCH    3   number of input channels, 2..16
//  SELW   2   width of sel/out_src; must satisfy 2**SELW >= NCH
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_data    in   NCH*WIDTH   channel i at [i*WIDTH +: WIDTH]
//  in_valid   in   NCH         channel i has data
//  in_ready   out  NCH         channel i transfers this cycle when in_valid[i] & in_ready[i]
//  mode       in   1           0 = fixed select, 1 = round-robin
//  sel        in   SELW        channel index used in mode 0
//  out_data   out  WIDTH       registered selected data
//  out_src    out  SELW        index of the channel that supplied out_data
//  out_valid  out  1           out_data/out_src hold a word
//  out_ready  in   1           consumer accepts the word when out_valid & out_ready
//  sel_err    out  1           registered: previous cycle had mode=0 and sel>=NCH
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, sel_err=0, rr_ptr=NCH-1.
//  - in_ready carries no reset state.
//  Load enable: load_ok = !out_valid | out_ready. The output register is EMPTY when out_valid=0, else FULL.
//  Grant (combinational, one-hot or zero, from in_valid/mode/sel/rr_ptr):
//   - mode 0: grant[sel] = in_valid[sel] when sel<NCH; otherwise no grant.
//   - mode 1: grant the first valid channel searching rr_ptr+1, rr_ptr+2, ... modulo NCH.
//  Handshake and transfer:
//   - in_ready[i] = grant[i] & load_ok, so at most one in_ready is high per cycle.
//   - in_ready may depend combinationally on in_valid, mode, sel and out_ready.
//   - Upstream must not make in_valid depend on in_ready.
//   - Transfer when any grant & load_ok: next edge out_data=in_data[g], out_src=g, out_valid=1.
//   - Latency: 1 cycle from transfer to out_valid.
//   - Full throughput: one word per cycle when out_ready is held 1.
//  Drain and hold:
//   - Drain with no transfer: out_valid -> 0. out_data and out_src keep their last value.
//   - Hold: while out_valid & !out_ready, out_data and out_src stay stable, and all in_ready=0.
//  rr_ptr:
//   - Updates to g only on a mode-1 transfer. It is unchanged in mode 0 and when idle.
//   - Wrap-around: with rr_ptr=NCH-1, the search starts at channel 0.
//  Boundary conditions:
//   - Mode or sel change: affects only the next grant. A word already held is unaffected.
//   - Out-of-range sel: no channel is granted. A held word drains normally. The sel_err pulse persists while the condition holds.
//   - No in_valid: no transfer. In mode 1 rr_ptr is unchanged.
//   - Simultaneous drain and load in the same cycle: the new word replaces the old one. out_valid stays 1, with no bubble.
//   - Reset mid-operation: a held word is discarded. rr_ptr returns to NCH-1. No in_ready is asserted while rst_n=0.
// TESTING (WIDTH=16, NCH=3, SELW=2; channel 0/1/2 data = AAAA/5555/FFFF)
//  1. Fixed select, out_ready=1, all valid.
//     mode=0, sel=0,1,2 on consecutive cycles -> out_data AAAA,5555,FFFF and out_src 0,1,2, each one cycle after its in_ready.
//  2. Round-robin, all valid, out_ready=1, from reset.
//     mode=1 -> grants 0,1,2,0,1,... and out_data AAAA,5555,FFFF,AAAA on back-to-back cycles.
//  3. Backpressure.
//     out_ready=0 after the first word -> out_data holds AAAA, in_ready=000 for 5 cycles.
//     Raising out_ready -> the next word arrives the following cycle, with no loss or duplication.
//  4. Out-of-range select.
//     mode=0, sel=3, all valid -> in_ready=000, out_valid falls after drain, sel_err=1 one cycle later.
//     sel=1 -> sel_err=0 next cycle and 5555 is delivered.
//  5. Sparse round-robin.
//     in_valid=101 after grant 0 -> next grant 2, then 0 (wrap). Channel 1 is never granted.
//  6. Reset while FULL.
//     Pulse rst_n=0 asynchronously mid-cycle -> out_valid=0 immediately, out_data=0.
//     First mode-1 grant after release is channel 0.

Source files
------------

// File: rtl/arb_mux_reg.sv
// Registered N-channel selector with fixed-select or round-robin grant,
// valid/ready handshakes on every channel and a one-entry output register.
module arb_mux_reg #(
   parameter int WIDTH = 16,
   parameter int NCH   = 3,
   parameter int SELW  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*WIDTH-1:0]   in_data,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic                   mode,
   input  logic [SELW-1:0]        sel,
   output logic [WIDTH-1:0]       out_data,
   output logic [SELW-1:0]        out_src,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   sel_err
);

   localparam logic [SELW:0]   NCH_W   = (SELW+1)'(NCH);
   localparam logic [SELW-1:0] LAST_CH = SELW'(NCH-1);

   logic [NCH-1:0]   grant;
   logic [SELW:0]    cand;
   logic             found;
   logic [SELW-1:0]  gidx;
   logic [WIDTH-1:0] gdata;
   logic             load_ok;
   logic             xfer;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_src_q,   out_src_d;
   logic             sel_err_q,   sel_err_d;
   logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

   // Round-robin search walks rr_ptr+1 .. rr_ptr+NCH, folding once past NCH-1.
   always_comb begin
      grant = '0;
      found = 1'b0;
      cand  = '0;
      if (!mode) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (SELW'(i) == sel) grant[i] = in_valid[i];
         end
      end else begin
         for (int unsigned k = 1; k <= NCH; k++) begin
            cand = {1'b0, rr_ptr_q} + (SELW+1)'(k);
            if (cand >= NCH_W) cand = cand - NCH_W;
            if (!found && in_valid[cand[SELW-1:0]]) begin
               grant[cand[SELW-1:0]] = 1'b1;
               found                 = 1'b1;
            end
         end
      end
   end

   always_comb begin
      gidx  = '0;
      gdata = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant[i]) begin
            gidx  = SELW'(i);
            gdata = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign load_ok  = !out_valid_q | out_ready;
   assign in_ready = rst_n ? (grant & {NCH{load_ok}}) : '0;
   assign xfer     = |in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      sel_err_d   = !mode & ({1'b0, sel} >= NCH_W);
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = gdata;
         out_src_d   = gidx;
         if (mode) rr_ptr_d = gidx;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         sel_err_q   <= 1'b0;
         rr_ptr_q    <= LAST_CH;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         sel_err_q   <= sel_err_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: a behavioural grant/output model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_arb_mux_reg;

   localparam int WIDTH = 16;
   localparam int NCH   = 3;
   localparam int SELW  = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_valid;
   logic [NCH-1:0]       in_ready;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_src;
   logic                 out_valid;
   logic                 out_ready;
   logic                 sel_err;

   arb_mux_reg #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready),
      .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   bit checking   = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the channel that wins this cycle, or -1.
   function automatic int mgrant(input bit md, input int s, input logic [2:0] v, input int ptr);
      if (!md) begin
         if (s < NCH) return v[s] ? s : -1;
         return -1;
      end
      for (int k = 1; k <= NCH; k++) begin
         int c;
         c = (ptr + k) % NCH;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   bit          m_valid;
   logic [15:0] m_data;
   int          m_src;
   int          m_ptr;
   bit          m_err;

   always @(posedge clk or negedge rst_n) begin : model
      int g;
      if (!rst_n) begin
         m_valid = 1'b0; m_data = '0; m_src = 0; m_err = 1'b0; m_ptr = NCH-1;
      end else begin
         g     = mgrant(mode, int'(sel), in_valid, m_ptr);
         m_err = !mode && (int'(sel) >= NCH);
         if (g >= 0 && (!m_valid || out_ready)) begin
            m_data  = in_data[g*WIDTH +: WIDTH];
            m_src   = g;
            m_valid = 1'b1;
            if (mode) m_ptr = g;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   function automatic logic [2:0] exp_ready();
      int g;
      g = mgrant(mode, int'(sel), in_valid, m_ptr);
      if (rst_n !== 1'b1 || g < 0 || !(!m_valid || out_ready)) return 3'b000;
      return 3'(1 << g);
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         chk("in_ready",  32'(in_ready),  32'(exp_ready()));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("out_data",  32'(out_data),  32'(m_data));
         chk("out_src",   32'(out_src),   32'(m_src));
         chk("sel_err",   32'(sel_err),   32'(m_err));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit md, input logic [1:0] s, input logic [2:0] v, input bit r);
      mode = md; sel = s; in_valid = v; out_ready = r;
   endtask

   task automatic ir(input string nm, input logic [2:0] exp);
      #1;
      chk(nm, 32'(in_ready), 32'(exp));
   endtask

   task automatic outw(input string nm, input logic [15:0] d, input logic [1:0] s);
      chk({nm, "_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_data"},  32'(out_data),  32'(d));
      chk({nm, "_src"},   32'(out_src),   32'(s));
   endtask

   // {mode, sel[1:0], in_valid[2:0], out_ready}
   logic [6:0] tbl [10] = '{7'b1_00_111_0, 7'b1_00_111_1, 7'b0_11_111_1, 7'b0_10_011_1,
                            7'b1_00_110_1, 7'b1_00_000_1, 7'b0_01_010_0, 7'b1_00_011_1,
                            7'b0_00_001_0, 7'b0_11_000_1};

   initial begin
      rst_n   = 1'b0;
      in_data = {16'hFFFF, 16'h5555, 16'hAAAA};
      drive(1'b1, 2'd0, 3'b111, 1'b1);
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_src",   32'(out_src),   32'd0);
      chk("rst_sel_err",   32'(sel_err),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      rst_n    = 1'b1;
      checking = 1'b1;

      // 1: fixed select
      drive(1'b0, 2'd0, 3'b111, 1'b1); ir("t1_rdy0", 3'b001); step(); outw("t1_w0", 16'hAAAA, 2'd0);
      sel = 2'd1;                      ir("t1_rdy1", 3'b010); step(); outw("t1_w1", 16'h5555, 2'd1);
      sel = 2'd2;                      ir("t1_rdy2", 3'b100); step(); outw("t1_w2", 16'hFFFF, 2'd2);

      // 2: round-robin from reset pointer
      mode = 1'b1; ir("t2_rdy0", 3'b001); step(); outw("t2_w0", 16'hAAAA, 2'd0);
      ir("t2_rdy1", 3'b010); step(); outw("t2_w1", 16'h5555, 2'd1);
      step(); outw("t2_w2", 16'hFFFF, 2'd2);
      step(); outw("t2_w3", 16'hAAAA, 2'd0);

      // 3: backpressure
      drive(1'b0, 2'd0, 3'b111, 1'b1); step(); outw("t3_first", 16'hAAAA, 2'd0);
      out_ready = 1'b0; ir("t3_stall_rdy", 3'b000);
      for (int i = 0; i < 5; i++) begin
         step();
         outw("t3_hold", 16'hAAAA, 2'd0);
         chk("t3_hold_rdy", 32'(in_ready), 32'd0);
      end
      sel = 2'd1; out_ready = 1'b1; ir("t3_resume_rdy", 3'b010);
      step(); outw("t3_next", 16'h5555, 2'd1);

      // 4: out-of-range select
      sel = 2'd3; ir("t4_rdy", 3'b000);
      step();
      chk("t4_drained", 32'(out_valid), 32'd0);
      chk("t4_sel_err", 32'(sel_err),   32'd1);
      sel = 2'd1; ir("t4_rdy_ok", 3'b010);
      step();
      chk("t4_err_clr", 32'(sel_err), 32'd0);
      outw("t4_w", 16'h5555, 2'd1);

      // 5: sparse round-robin (pointer left at channel 0)
      drive(1'b1, 2'd0, 3'b101, 1'b1); ir("t5_rdy_a", 3'b100); step(); outw("t5_w0", 16'hFFFF, 2'd2);
      ir("t5_rdy_b", 3'b001); step(); outw("t5_w1", 16'hAAAA, 2'd0);
      ir("t5_rdy_c", 3'b100); step(); outw("t5_w2", 16'hFFFF, 2'd2);

      // 6: reset while full
      drive(1'b1, 2'd0, 3'b111, 1'b0); step();
      chk("t6_full", 32'(out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_data",  32'(out_data),  32'd0);
      chk("t6_rst_rdy",   32'(in_ready),  32'd0);
      #1 rst_n = 1'b1;
      step(); outw("t6_after", 16'hAAAA, 2'd0);

      // Mixed directed vectors, checked by the per-cycle model
      for (int i = 0; i < 10; i++) begin
         logic [6:0] v;
         v = tbl[i];
         drive(v[6], v[5:4], v[3:1], v[0]);
         step();
      end
      drive(1'b0, 2'd0, 3'b000, 1'b1);
      step(); step();
      checking = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
